// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low codes (bit6=a .. bit0=g)
// and the scan-capture state type.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    S_TRACK,
    S_HELD
  } state_e;

endpackage

// File: rtl/seg_decode_lut.sv
// Inverse seven-segment table: active-low pattern to hex nibble.
// o_hit is low for any pattern outside the 16 digit codes.
module seg_decode_lut
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_hit
);

  always_comb begin
    o_nibble = 4'h0;
    o_hit    = 1'b1;
    case (i_seg)
      SEG_0:   o_nibble = 4'h0;
      SEG_1:   o_nibble = 4'h1;
      SEG_2:   o_nibble = 4'h2;
      SEG_3:   o_nibble = 4'h3;
      SEG_4:   o_nibble = 4'h4;
      SEG_5:   o_nibble = 4'h5;
      SEG_6:   o_nibble = 4'h6;
      SEG_7:   o_nibble = 4'h7;
      SEG_8:   o_nibble = 4'h8;
      SEG_9:   o_nibble = 4'h9;
      SEG_A:   o_nibble = 4'hA;
      SEG_B:   o_nibble = 4'hB;
      SEG_C:   o_nibble = 4'hC;
      SEG_D:   o_nibble = 4'hD;
      SEG_E:   o_nibble = 4'hE;
      SEG_F:   o_nibble = 4'hF;
      default: o_hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_decoder_scan.sv
// Captures a multiplexed active-low seven-segment bus, debounces each
// strobed digit and publishes whole decoded frames with a valid pulse.
module seg_decoder_scan
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DIGITS-1:0]     i_sel,
  input  logic [6:0]            i_seg,
  output logic [4*DIGITS-1:0]   o_num,
  output logic                  o_valid,
  output logic                  o_err
);

  localparam int         SW      = DIGITS + 7;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [SW-1:0]       sample_q, sample_d;
  logic [7:0]          cnt_q, cnt_d;
  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                eflag_q, eflag_d;
  logic [4*DIGITS-1:0] num_q, num_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic [3:0]        lut_nib;
  logic              lut_hit;
  logic              qual, same, capture;
  logic [DIGITS-1:0] mask_new;
  logic              eflag_new;

  seg_decode_lut u_lut (
    .i_seg    (i_seg),
    .o_nibble (lut_nib),
    .o_hit    (lut_hit)
  );

  always_comb begin
    qual      = $onehot(i_sel);
    same      = ({i_sel, i_seg} == sample_q);
    sample_d  = {i_sel, i_seg};
    cnt_d     = cnt_q;
    state_d   = state_q;
    shadow_d  = shadow_q;
    mask_d    = mask_q;
    eflag_d   = eflag_q;
    num_d     = num_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    capture   = 1'b0;
    mask_new  = mask_q;
    eflag_new = eflag_q;

    if (!qual) begin
      cnt_d   = 8'd0;
      state_d = S_TRACK;
    end else begin
      if (same)
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
      else
        cnt_d = 8'd1;
      if (state_q == S_HELD) begin
        if (!same) state_d = S_TRACK;
      end else if (cnt_d == CNT_MAX) begin
        capture = 1'b1;
        state_d = S_HELD;
      end
    end

    if (capture) begin
      for (int n = 0; n < DIGITS; n++)
        if (i_sel[n]) shadow_d[4*n +: 4] = lut_hit ? lut_nib : 4'h0;
      mask_new  = mask_q | i_sel;
      eflag_new = eflag_q | ~lut_hit;
      // The completing slot goes out on the same edge it is captured.
      if (&mask_new) begin
        num_d   = shadow_d;
        err_d   = eflag_new;
        valid_d = 1'b1;
        mask_d  = '0;
        eflag_d = 1'b0;
      end else begin
        mask_d  = mask_new;
        eflag_d = eflag_new;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sample_q <= '0;
      cnt_q    <= 8'd0;
      state_q  <= S_TRACK;
      shadow_q <= '0;
      mask_q   <= '0;
      eflag_q  <= 1'b0;
      num_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      eflag_q  <= eflag_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign o_num   = num_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;

endmodule
